// File: rtl/apb_aud_pwm.sv
`default_nettype none
// ============================================================================
// Module   : apb_aud_pwm
// Purpose  : APB audio PWM player. The core writes samples into a small FIFO.
//            One sample is popped per PWM frame (2^SAMPLE_WIDTH ticks) and
//            played out as a single-bit duty-cycle stream. The block also
//            raises a FIFO refill interrupt.
// Ports    : clk_i, rst_ni (async, active low)
//            PADDR/PWDATA/PWRITE/PSEL/PENABLE -> PRDATA/PREADY/PSLVERR (APB)
//            pwm_o  - PWM audio output (registered)
//            irq_o  - level refill interrupt (registered)
// Options  : AUD_PWM_UNDERRUN_IRQ_EN - sticky underrun also drives irq_o
// Revision : 1.0 - initial release
// ============================================================================
module apb_aud_pwm #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      pwm_o,
  output logic                      irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Register state
  logic                    en_q, irq_en_q, underrun_q, pwm_q, irq_q;
  logic [3:0]              thr_q;
  logic [15:0]             presc_q, pcnt_q;
  logic [SAMPLE_WIDTH-1:0] fcnt_q, duty_q;
  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [CNT_W-1:0]        count_q;

  // Decode
  logic [1:0] addr_w;
  logic       wr_w, wr_ctrl_w, wr_presc_w, wr_data_w, wr_status_w;
  logic       full_w, empty_w, tick_w, frame_end_w, pop_w, push_w, flush_w;
  logic       en_d, thr_hit_w, irq_d;
  logic       unused_bits;

  assign addr_w      = PADDR[3:2];
  assign wr_w        = PSEL & PENABLE & PWRITE;
  assign wr_ctrl_w   = wr_w & (addr_w == 2'd0);
  assign wr_presc_w  = wr_w & (addr_w == 2'd1);
  assign wr_data_w   = wr_w & (addr_w == 2'd2);
  assign wr_status_w = wr_w & (addr_w == 2'd3);
  assign unused_bits = ^{PADDR, PWDATA};

  assign full_w  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_w = (count_q == '0);

  // A PRESC write restarts the prescaler, so no tick is produced that cycle.
  assign tick_w      = en_q & (pcnt_q == presc_q) & ~wr_presc_w;
  assign frame_end_w = tick_w & (fcnt_q == {SAMPLE_WIDTH{1'b1}});
  assign pop_w       = frame_end_w & ~empty_w;
  assign flush_w     = wr_ctrl_w & PWDATA[2];
  // A full FIFO still accepts a sample when an entry leaves in the same cycle.
  assign push_w      = wr_data_w & (~full_w | pop_w) & ~flush_w;
  assign en_d        = wr_ctrl_w ? PWDATA[0] : en_q;

  assign thr_hit_w = (32'(count_q) <= 32'(thr_q));
`ifdef AUD_PWM_UNDERRUN_IRQ_EN
  assign irq_d = (irq_en_q & en_q & thr_hit_w) | (irq_en_q & underrun_q);
`else
  assign irq_d = irq_en_q & en_q & thr_hit_w;
`endif

  // Control registers and FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      thr_q      <= '0;
      presc_q    <= '0;
      underrun_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      en_q <= en_d;
      if (wr_ctrl_w) begin
        irq_en_q <= PWDATA[1];
        thr_q    <= PWDATA[7:4];
      end
      if (wr_presc_w) presc_q <= PWDATA[15:0];

      // Underrun set takes priority over a simultaneous software clear.
      if (frame_end_w & empty_w)          underrun_q <= 1'b1;
      else if (wr_status_w & PWDATA[10])  underrun_q <= 1'b0;

      if (push_w) mem_q[wptr_q] <= PWDATA[SAMPLE_WIDTH-1:0];
      if (flush_w) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_w) wptr_q <= wptr_q + PTR_W'(1);
        if (pop_w)  rptr_q <= rptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push_w) - CNT_W'(pop_w);
      end
    end
  end

  // Playback datapath; disabling clears it in the same cycle as the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= irq_d;
      pwm_q <= en_d & (fcnt_q < duty_q);
      if (!en_d) begin
        pcnt_q <= '0;
        fcnt_q <= '0;
        duty_q <= '0;
      end else begin
        if (wr_presc_w | tick_w) pcnt_q <= '0;
        else if (en_q)           pcnt_q <= pcnt_q + 16'd1;
        if (tick_w) fcnt_q <= fcnt_q + SAMPLE_WIDTH'(1);
        if (pop_w)  duty_q <= mem_q[rptr_q];
      end
    end
  end

  // Read mux
  always_comb begin
    PRDATA = '0;
    if (PSEL & ~PWRITE) begin
      case (addr_w)
        2'd0:    PRDATA = {24'd0, thr_q, 2'b00, irq_en_q, en_q};
        2'd1:    PRDATA = {16'd0, presc_q};
        2'd3:    PRDATA = {21'd0, underrun_q, full_w, empty_w, 3'b000, 5'(count_q)};
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = wr_data_w & full_w & ~pop_w;
  assign pwm_o   = pwm_q;
  assign irq_o   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_aud_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_aud_pwm
// Purpose  : Self-checking bench for apb_aud_pwm: register tables, directed
//            playback/irq/underrun/enable sequences, random APB traffic
//            against a queue-based reference model, and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_aud_pwm;
  localparam int AW = 12;
  localparam int DEPTH = 8;
`ifdef AUD_PWM_UNDERRUN_IRQ_EN
  localparam bit UNR_IRQ = 1'b1;
`else
  localparam bit UNR_IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic [31:0]   pwdata = '0;
  logic          pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0]   prdata;
  logic          pready, pslverr, pwm_o, irq_o;

  always #5 clk = ~clk;

  apb_aud_pwm #(.APB_ADDR_WIDTH(AW), .SAMPLE_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .PADDR(paddr), .PWDATA(pwdata),
    .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .pwm_o(pwm_o), .irq_o(irq_o));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_en = 0, m_irqen = 0, m_unr = 0, m_pwm = 0, m_irq = 0;
  int m_thr = 0, m_presc = 0, m_pcnt = 0, m_fcnt = 0, m_duty = 0;
  int m_q[$];
  bit t_wr, t_tick, t_fend, t_pop, t_en, t_pwm, t_irq;
  int t_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_irqen = 0; m_unr = 0; m_pwm = 0; m_irq = 0;
      m_thr = 0; m_presc = 0; m_pcnt = 0; m_fcnt = 0; m_duty = 0;
      m_q.delete();
    end else begin
      t_wr   = psel && penable && pwrite;
      t_a    = int'(paddr[3:2]);
      t_tick = m_en && (m_pcnt == m_presc) && !(t_wr && t_a == 1);
      t_fend = t_tick && (m_fcnt == 255);
      t_pop  = t_fend && (m_q.size() > 0);
      t_en   = (t_wr && t_a == 0) ? pwdata[0] : m_en;
      t_pwm  = t_en && (m_fcnt < m_duty);
      t_irq  = (m_irqen && m_en && (m_q.size() <= m_thr)) || (UNR_IRQ && m_irqen && m_unr);
      if (t_pop) m_duty = m_q.pop_front();
      if (t_fend && !t_pop) m_unr = 1;
      else if (t_wr && t_a == 3 && pwdata[10]) m_unr = 0;
      if (t_wr && t_a == 2 && m_q.size() < DEPTH) m_q.push_back(int'(pwdata[7:0]));
      if (t_wr && t_a == 0) begin
        if (pwdata[2]) m_q.delete();
        m_irqen = pwdata[1];
        m_thr   = int'(pwdata[7:4]);
      end
      if (t_tick) begin m_pcnt = 0; m_fcnt = (m_fcnt + 1) % 256; end
      else if (m_en) m_pcnt++;
      if (t_wr && t_a == 1) begin m_presc = int'(pwdata[15:0]); m_pcnt = 0; end
      m_en = t_en;
      if (!m_en) begin m_pcnt = 0; m_fcnt = 0; m_duty = 0; end
      m_pwm = t_pwm;
      m_irq = t_irq;
    end
  end

  function automatic logic [31:0] m_rd(input int a);
    int n;
    n = m_q.size();
    case (a)
      0: return 32'(m_thr * 16 + m_irqen * 2 + m_en);
      1: return 32'(m_presc);
      3: return 32'(n + (n == 0) * 256 + (n == DEPTH) * 512 + m_unr * 1024);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_pop_now();
    return m_en && (m_pcnt == m_presc) && (m_fcnt == 255) && (m_q.size() > 0);
  endfunction

  // Continuous output comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pwm_o vs model", 32'(pwm_o), 32'(m_pwm));
      chk("irq_o vs model", 32'(irq_o), 32'(m_irq));
    end
  end

  // ---------------- APB access ----------------
  task automatic apb(input bit w, input logic [AW-1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = w; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1;
    #1;
    rd = prdata; err = pslverr;
    if (!w) chk("prdata vs model", rd, m_rd(int'(addr[3:2])));
    chk("pslverr vs model", 32'(err),
        32'(w && addr[3:2] == 2'd2 && m_q.size() == DEPTH && !m_pop_now()));
    @(negedge clk);
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err;
    apb(1'b1, addr, wd, rd, err);
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb(1'b0, addr, 32'd0, rd, err);
    chk(name, rd, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          w;
    logic [11:0] addr;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic run_table(input int lo, input int hi);
    logic [31:0] rd; logic err;
    for (int i = lo; i <= hi; i++) begin
      apb(tbl[i].w, tbl[i].addr, tbl[i].wd, rd, err);
      if (tbl[i].chk_rd) chk(tbl[i].name, rd, tbl[i].exp_rd);
      chk({tbl[i].name, " err"}, 32'(err), 32'(tbl[i].exp_err));
    end
  endtask

  initial begin
    int h1, h2, k;
    bit seen;
    logic [31:0] rd; logic err;

    tbl.push_back('{0, 12'h0, 0, 1, 32'h0,   0, "rst CTRL"});
    tbl.push_back('{0, 12'h4, 0, 1, 32'h0,   0, "rst PRESC"});
    tbl.push_back('{0, 12'h8, 0, 1, 32'h0,   0, "rst DATA"});
    tbl.push_back('{0, 12'hC, 0, 1, 32'h100, 0, "rst STATUS"});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1, 12'h8, 32'(8'h10 + i), 0, 32'h0, 0, "fill push"});
    tbl.push_back('{1, 12'h8, 32'hEE, 0, 32'h0,   1, "overflow push"});
    tbl.push_back('{0, 12'hC, 0,      1, 32'h208, 0, "full STATUS"});
    tbl.push_back('{0, 12'h8, 0,      1, 32'h0,   0, "DATA reads 0"});
    tbl.push_back('{1, 12'h0, 32'h4,  0, 32'h0,   0, "flush"});
    tbl.push_back('{0, 12'hC, 0,      1, 32'h100, 0, "flushed STATUS"});
    tbl.push_back('{0, 12'h0, 0,      1, 32'h0,   0, "flush self-clears"});

    // Reset
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset pwm_o", 32'(pwm_o), 0);
    chk("reset irq_o", 32'(irq_o), 0);
    chk("reset PRDATA idle", prdata, 0);
    chk("reset PSLVERR", 32'(pslverr), 0);
    run_table(0, 3);

    // Duty 0x40 at PRESC=0: first frame silent, then 64 high cycles
    wr(12'h8, 32'h40);
    wr(12'h0, 32'h1);
    h1 = 0; h2 = 0;
    repeat (250) begin @(negedge clk); h1 += int'(pwm_o); end
    repeat (150) begin @(negedge clk); h2 += int'(pwm_o); end
    chk("first frame high count", 32'(h1), 0);
    chk("duty 0x40 high count", 32'(h2), 64);
    rd_chk("STATUS after pop", 12'hC, 32'h100);
    wr(12'h0, 32'h0);

    // Overflow / flush table
    run_table(4, tbl.size() - 1);

    // Threshold interrupt
    for (int i = 0; i < 4; i++) wr(12'h8, 32'(i + 1));
    wr(12'h0, 32'h23);
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin @(negedge clk); seen = irq_o; end
    chk("irq rises at count<=THR", 32'(seen), 1);
    rd_chk("STATUS at irq", 12'hC, 32'h002);
    wr(12'h8, 32'h5);
    chk("irq held after push", 32'(irq_o), 1);
    @(negedge clk);
    chk("irq drops after push", 32'(irq_o), 0);
    wr(12'h0, 32'h4);

    // Underrun: duty 0x80 repeats, sticky bit, optional irq
    wr(12'h8, 32'h80);
    wr(12'h0, 32'h03);
    repeat (800) @(negedge clk);
    rd_chk("STATUS underrun", 12'hC, 32'h500);
    h1 = 0;
    repeat (256) begin @(negedge clk); h1 += int'(pwm_o); end
    chk("repeated duty 0x80", 32'(h1), 128);
    wr(12'h4, 32'hFFFF);
    wr(12'h8, 32'h11);
    repeat (2) @(negedge clk);
    chk("irq from underrun", 32'(irq_o), 32'(UNR_IRQ));
    wr(12'hC, 32'h400);
    @(negedge clk);
    chk("irq after underrun clear", 32'(irq_o), 0);
    rd_chk("STATUS underrun cleared", 12'hC, 32'h001);
    wr(12'h0, 32'h4);

    // PRESC=3, mid-frame disable, restart timing
    wr(12'h4, 32'h3);
    wr(12'h8, 32'hFF);
    wr(12'h0, 32'h1);
    repeat (1224) @(negedge clk);
    chk("pwm high mid-frame", 32'(pwm_o), 1);
    wr(12'h0, 32'h0);
    chk("pwm cleared by EN=0", 32'(pwm_o), 0);
    wr(12'h8, 32'h80);
    wr(12'h0, 32'h1);
    k = 0; seen = 0;
    while (!seen && k < 3000) begin @(negedge clk); k++; seen = pwm_o; end
    chk("rise after 1024-cycle frame", 32'(k), 1025);
    h1 = 0;
    while (pwm_o && h1 < 3000) begin @(negedge clk); h1++; end
    chk("high time at PRESC=3", 32'(h1), 512);
    wr(12'h0, 32'h4);
    wr(12'hC, 32'h400);

    // Random traffic against the model
    wr(12'h4, 32'($urandom_range(0, 1)));
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wr(12'h8, 32'($urandom_range(0, 255)));
        5: apb(1'b0, 12'(4 * $urandom_range(0, 3)), 32'd0, rd, err);
        6: wr(12'h0, {24'd0, 4'($urandom_range(0, 15)), 1'b0,
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 5) != 0)});
        7: wr(12'hC, 32'($urandom) & 32'h7FF);
        8: repeat ($urandom_range(0, 300)) @(negedge clk);
        default: wr(12'h4, 32'($urandom_range(0, 2)));
      endcase
    end

    // Asynchronous reset while pwm is high
    wr(12'h4, 32'h0);
    wr(12'h8, 32'hC0);
    wr(12'h0, 32'h5);
    wr(12'h8, 32'hC0);
    wr(12'h0, 32'h1);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin @(negedge clk); seen = pwm_o; end
    chk("pwm high before reset", 32'(seen), 1);
    #3 rst_n = 0;
    #1;
    chk("async reset pwm_o", 32'(pwm_o), 0);
    chk("async reset irq_o", 32'(irq_o), 0);
    @(negedge clk);
    rst_n = 1;
    rd_chk("STATUS after async reset", 12'hC, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
